// File: rtl/acq_sequencer_pkg.sv
// Shared definitions for the acquisition sequencer: register map entries,
// mode-bit positions and state encodings.
package acq_sequencer_pkg;

  localparam int REG_ADDR_WIDTH = 8;
  localparam int REG_DATA_WIDTH = 16;

  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ACQ_MODE       = 8'd16;
  localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ACQ_TIMEOUT    = 8'd17;
  localparam logic [REG_DATA_WIDTH-1:0] DEFAULT_ACQ_MODE    = 16'h0006;
  localparam logic [REG_DATA_WIDTH-1:0] DEFAULT_ACQ_TIMEOUT = 16'd3900;

  localparam int MODE_CONTINUOUS = 0;
  localparam int MODE_CHA_EN     = 1;
  localparam int MODE_CHB_EN     = 2;
  localparam int MODE_AUTO_TRIG  = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_READ_A    = 3'd3,
    ST_READ_B    = 3'd4,
    ST_DONE      = 3'd5
  } acq_state_e;

  // First readout state after capture, skipping disabled channels.
  function automatic acq_state_e after_capture(input logic cha_en, input logic chb_en);
    if (cha_en)      return ST_READ_A;
    else if (chb_en) return ST_READ_B;
    else             return ST_DONE;
  endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Register bus, host control and datapath handshake signals of the
// acquisition sequencer.
interface acq_sequencer_if;
  import acq_sequencer_pkg::*;

  logic [REG_ADDR_WIDTH-1:0] register_addr;
  logic [REG_DATA_WIDTH-1:0] register_data;
  logic                      register_rdy;
  logic                      host_start;
  logic                      host_stop;
  logic                      triggered_i;
  logic                      capture_done_i;
  logic                      chA_frame_done_i;
  logic                      chB_frame_done_i;
  logic                      start_o;
  logic                      stop_o;
  logic                      force_trig_o;
  logic                      rqst_chA_o;
  logic                      rqst_chB_o;
  logic                      busy_o;
  logic [2:0]                state_o;

  modport slave (
    input  register_addr, register_data, register_rdy,
    input  host_start, host_stop, triggered_i, capture_done_i,
    input  chA_frame_done_i, chB_frame_done_i,
    output start_o, stop_o, force_trig_o, rqst_chA_o, rqst_chB_o,
    output busy_o, state_o
  );

  modport master (
    output register_addr, register_data, register_rdy,
    output host_start, host_stop, triggered_i, capture_done_i,
    output chA_frame_done_i, chB_frame_done_i,
    input  start_o, stop_o, force_trig_o, rqst_chA_o, rqst_chB_o,
    input  busy_o, state_o
  );

endinterface

// File: rtl/acq_sequencer_timeout_counter.sv
// Auto-trigger timer: 8-bit prescaler feeding a saturating 16-bit counter of
// 256-cycle units, compared against the programmed timeout.
module acq_timeout_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] timeout,
  output logic        expired
);

  logic [7:0]  prescale;
  logic [15:0] count;
  logic [15:0] count_inc;
  logic        tick;

  assign tick      = enable && (prescale == 8'hff);
  assign count_inc = (tick && (count != 16'hffff)) ? count + 16'd1 : count;
  // Compare includes this cycle's tick, so N units expire N*256 cycles after arming.
  assign expired   = enable && (count_inc >= timeout);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale <= '0;
      count    <= '0;
    end else if (clear) begin
      prescale <= '0;
      count    <= '0;
    end else if (enable) begin
      prescale <= prescale + 8'd1;
      count    <= count_inc;
    end
  end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition scheduler: arms the trigger, waits for capture, then drains
// channel A and B frames, optionally re-arming in continuous mode.
//
// state     | meaning
// IDLE      | waiting for host_start
// WAIT_TRIG | trigger armed, waiting for triggered_i (auto trigger may force)
// CAPTURE   | triggered, waiting for capture_done_i
// READ_A    | channel A frame requested, waiting for chA_frame_done_i
// READ_B    | channel B frame requested, waiting for chB_frame_done_i
// DONE      | one cycle: re-arm (continuous) or return to IDLE
module acq_sequencer
  import acq_sequencer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  acq_sequencer_if.slave bus
);

  logic [REG_DATA_WIDTH-1:0] mode;
  logic [REG_DATA_WIDTH-1:0] timeout;
  acq_state_e                state;
  logic start_q, stop_q, force_q, rqst_a_q, rqst_b_q, busy_q;
  logic forced;
  logic cap_pending;
  logic timer_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode    <= DEFAULT_ACQ_MODE;
      timeout <= DEFAULT_ACQ_TIMEOUT;
    end else if (bus.register_rdy) begin
      if (bus.register_addr == ADDR_ACQ_MODE)
        mode <= bus.register_data;
      else if (bus.register_addr == ADDR_ACQ_TIMEOUT)
        timeout <= bus.register_data;
    end
  end

  acq_timeout_counter u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (state != ST_WAIT_TRIG),
    .enable  (state == ST_WAIT_TRIG),
    .timeout (timeout),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      force_q     <= 1'b0;
      rqst_a_q    <= 1'b0;
      rqst_b_q    <= 1'b0;
      busy_q      <= 1'b0;
      forced      <= 1'b0;
      cap_pending <= 1'b0;
    end else begin
      start_q  <= 1'b0;
      stop_q   <= 1'b0;
      force_q  <= 1'b0;
      rqst_a_q <= 1'b0;
      rqst_b_q <= 1'b0;
      busy_q   <= 1'b1;
      if (state != ST_IDLE && bus.host_stop) begin
        stop_q      <= 1'b1;
        state       <= ST_IDLE;
        busy_q      <= 1'b0;
        cap_pending <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.host_start) begin
              start_q <= 1'b1;
              forced  <= 1'b0;
              state   <= ST_WAIT_TRIG;
            end else begin
              busy_q <= 1'b0;
            end
          end
          ST_WAIT_TRIG: begin
            if (bus.triggered_i) begin
              state       <= ST_CAPTURE;
              cap_pending <= bus.capture_done_i;
            end else if (mode[MODE_AUTO_TRIG] && timer_expired && !forced) begin
              force_q <= 1'b1;
              forced  <= 1'b1;
            end
          end
          ST_CAPTURE: begin
            if (bus.capture_done_i || cap_pending) begin
              cap_pending <= 1'b0;
              state    <= after_capture(mode[MODE_CHA_EN], mode[MODE_CHB_EN]);
              rqst_a_q <= after_capture(mode[MODE_CHA_EN], mode[MODE_CHB_EN]) == ST_READ_A;
              rqst_b_q <= after_capture(mode[MODE_CHA_EN], mode[MODE_CHB_EN]) == ST_READ_B;
            end
          end
          ST_READ_A: begin
            if (bus.chA_frame_done_i) begin
              if (mode[MODE_CHB_EN]) begin
                state    <= ST_READ_B;
                rqst_b_q <= 1'b1;
              end else begin
                state <= ST_DONE;
              end
            end
          end
          ST_READ_B: begin
            if (bus.chB_frame_done_i)
              state <= ST_DONE;
          end
          ST_DONE: begin
            if (mode[MODE_CONTINUOUS]) begin
              start_q <= 1'b1;
              forced  <= 1'b0;
              state   <= ST_WAIT_TRIG;
            end else begin
              state  <= ST_IDLE;
              busy_q <= 1'b0;
            end
          end
          default: begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.start_o      = start_q;
  assign bus.stop_o       = stop_q;
  assign bus.force_trig_o = force_q;
  assign bus.rqst_chA_o   = rqst_a_q;
  assign bus.rqst_chB_o   = rqst_b_q;
  assign bus.busy_o       = busy_q;
  assign bus.state_o      = state;

endmodule
